// File: rtl/shift_register_engine.sv
// Programmable-period strobe generator driving a WIDTH-bit shift/rotate register with parallel load.
// Optional macro SHIFT_REGISTER_ENGINE_STICKY_INPUT_EN latches serial_in pulses between ticks.
module shift_register_engine #(
  parameter int WIDTH     = 10,
  parameter int DIV_WIDTH = 22
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic [1:0]           mode,
  input  logic                 serial_in,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_data,
  output logic [WIDTH-1:0]     q,
  output logic                 serial_out,
  output logic                 strobe
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic                 strobe_q, strobe_d;
  logic                 tick;
  logic                 in_bit;

`ifdef SHIFT_REGISTER_ENGINE_STICKY_INPUT_EN
  logic sticky_q, sticky_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  // A 1 on serial_in during the tick cycle is consumed by the shift, not kept.
  always_comb begin
    sticky_d = sticky_q | serial_in;
    if (load || tick) sticky_d = 1'b0;
    in_bit = sticky_q | serial_in;
  end
`else
  always_comb in_bit = serial_in;
`endif

  always_comb begin
    tick = enable && (counter_q == '0) && !load;

    counter_d = counter_q;
    if (load || tick) counter_d = period;
    else if (enable)  counter_d = counter_q - CNT_ONE;

    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (tick) begin
      case (mode)
        2'd0:    shreg_d = {in_bit, shreg_q[WIDTH-1:1]};
        2'd1:    shreg_d = {shreg_q[WIDTH-2:0], in_bit};
        2'd2:    shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
        default: shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      endcase
    end

    strobe_d = tick;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      shreg_q   <= '0;
      strobe_q  <= 1'b0;
    end else begin
      counter_q <= counter_d;
      shreg_q   <= shreg_d;
      strobe_q  <= strobe_d;
    end
  end

  assign q          = shreg_q;
  assign strobe     = strobe_q;
  assign serial_out = mode[0] ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: tb/tb_shift_register_engine.sv
// Directed plus randomized bench for shift_register_engine against a cycle-level reference model.
module tb_shift_register_engine;
  localparam int W  = 10;
  localparam int DW = 4;
  localparam int MASK = (1 << W) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] period;
  logic [1:0]    mode;
  logic          serial_in;
  logic          load;
  logic [W-1:0]  load_data;
  logic [W-1:0]  q;
  logic          serial_out;
  logic          strobe;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_q, m_cnt;
  bit m_sticky, m_strobe;

  shift_register_engine #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .period(period), .mode(mode),
    .serial_in(serial_in), .load(load), .load_data(load_data),
    .q(q), .serial_out(serial_out), .strobe(strobe)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_sticky = 0; m_strobe = 0;
  endtask

  // One clock edge: predict from the inputs in force, then compare after the edge.
  task automatic step();
    bit tick, in_bit;
    int nq, ncnt;
    bit nsticky;
    tick = enable && (m_cnt == 0) && !load;
`ifdef SHIFT_REGISTER_ENGINE_STICKY_INPUT_EN
    in_bit = m_sticky | serial_in;
`else
    in_bit = serial_in;
`endif
    nq = m_q;
    if (load) nq = int'(load_data);
    else if (tick) begin
      case (mode)
        2'd0: nq = (m_q >> 1) | (int'(in_bit) << (W - 1));
        2'd1: nq = ((m_q << 1) | int'(in_bit)) & MASK;
        2'd2: nq = (m_q >> 1) | ((m_q & 1) << (W - 1));
        default: nq = ((m_q << 1) | (m_q >> (W - 1))) & MASK;
      endcase
    end
    ncnt = m_cnt;
    if (load || tick) ncnt = int'(period);
    else if (enable) ncnt = m_cnt - 1;
    nsticky = (load || tick) ? 1'b0 : (m_sticky | serial_in);
    @(posedge clock);
    #1;
    m_q = nq; m_cnt = ncnt; m_sticky = nsticky; m_strobe = tick;
    check("q", 32'(q), 32'(m_q));
    check("strobe", 32'(strobe), 32'(m_strobe));
    check("serial_out", 32'(serial_out),
          (mode == 2'd1 || mode == 2'd3) ? 32'((m_q >> (W - 1)) & 1) : 32'(m_q & 1));
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; period = '0; mode = 2'd0;
    serial_in = 1'b0; load = 1'b0; load_data = '0;
    model_reset();
    #12;
    check("reset_q", 32'(q), 32'h0);
    check("reset_strobe", 32'(strobe), 32'h0);

    // Period 3, shift right with serial_in=1
    period = 4'd3; enable = 1'b1; serial_in = 1'b1; mode = 2'd0;
    #10 reset = 1'b0;
    step();
    check("edge1_q", 32'(q), 32'h200);
    for (int i = 2; i <= 9; i++) begin
      step();
      if (i == 5) check("edge5_q", 32'(q), 32'h300);
    end
    check("edge9_q", 32'(q), 32'h380);

    // Rotate right / left with period 0
    serial_in = 1'b0; period = 4'd0;
    load = 1'b1; load_data = 10'h001; mode = 2'd2;
    step();
    load = 1'b0;
    step(); check("rotr1", 32'(q), 32'h200);
    step(); check("rotr2", 32'(q), 32'h100);
    load = 1'b1; load_data = 10'h001; mode = 2'd3;
    step();
    load = 1'b0;
    step(); check("rotl1", 32'(q), 32'h002);
    check("rotl_sout", 32'(serial_out), 32'h0);

    // Load colliding with a tick
    period = 4'd3; mode = 2'd0;
    for (int i = 0; i < 8 && m_cnt != 0; i++) step();
    load = 1'b1; load_data = 10'h155;
    step();
    check("collide_q", 32'(q), 32'h155);
    check("collide_strobe", 32'(strobe), 32'h0);
    load = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (strobe === 1'b1 && n == 0) n = i;
    end
    check("collide_interval", 32'(n), 32'd4);

    // Enable low mid-count freezes everything
    step();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) step();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Asynchronous reset between edges, right after a strobe
    period = 4'd0;
    step(); step();
    #3 reset = 1'b1;
    #1;
    check("async_q", 32'(q), 32'h0);
    check("async_strobe", 32'(strobe), 32'h0);
    model_reset();
    #2 reset = 1'b0;

    // Single-cycle serial_in pulse between ticks
    period = 4'd7; mode = 2'd0; serial_in = 1'b0;
    step();
    step(); step();
    serial_in = 1'b1;
    step();
    serial_in = 1'b0;
    for (int i = 0; i < 12 && !m_strobe; i++) step();
`ifdef SHIFT_REGISTER_ENGINE_STICKY_INPUT_EN
    check("sticky_bit", 32'(q[W-1]), 32'h1);
`else
    check("sticky_bit", 32'(q[W-1]), 32'h0);
`endif

    // Period change 3 -> 1 at counter = 2
    period = 4'd3; load = 1'b1; load_data = 10'h0f0;
    step();
    load = 1'b0;
    step();
    period = 4'd1;
    n = 1;
    for (int i = 2; i <= 8 && strobe !== 1'b1; i++) begin
      step();
      n = i;
    end
    check("pchg_first", 32'(n), 32'd4);
    n = 0;
    for (int i = 1; i <= 4 && n == 0; i++) begin
      step();
      if (strobe === 1'b1) n = i;
    end
    check("pchg_next", 32'(n), 32'd2);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      period    = DW'($urandom_range(0, 3));
      mode      = 2'($urandom_range(0, 3));
      serial_in = 1'($urandom);
      load      = ($urandom_range(0, 15) == 0);
      load_data = W'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
